// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one multi-cycle square-root datapath
// among N_REQ requesters, one operation in flight at a time.
module sqrt_arbiter #(
  parameter  int N_REQ    = 4,
  parameter  int SQRT_LAT = 15,
  localparam int IDW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic               rsp_valid_o,
  output logic [IDW-1:0]     rsp_id_o,
  output logic [7:0]         rsp_data_o,
  input  logic               rsp_ready_i,
  output logic [7:0]         sqrt_dt_o,
  output logic               sqrt_enb_o,
  input  logic [7:0]         sqrt_dt_i,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_RESP
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic [7:0]     r_op;
  logic [7:0]     r_rsp;
  logic [7:0]     r_cnt;
  logic [IDW-1:0] w_win;
  logic [IDW:0]   w_idx;
  logic           w_found;
  logic           w_grant;
  logic           w_last;

  // First valid requester at or above r_ptr, wrapping to 0
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(i);
      if (w_idx >= (IDW+1)'(N_REQ))
        w_idx = w_idx - (IDW+1)'(N_REQ);
      if (!w_found && req_valid_i[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[IDW-1:0];
      end
    end
  end

  assign w_grant = (r_state == S_IDLE) && w_found && !rst_i;
  assign w_last  = (r_cnt == 8'(SQRT_LAT - 1));

  always_comb begin
    req_ready_o = '0;
    if (w_grant)
      req_ready_o = N_REQ'(1) << w_win;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_found)     w_next = S_RUN;
      S_RUN:  if (w_last)      w_next = S_RESP;
      S_RESP: if (rsp_ready_i) w_next = S_IDLE;
      default:                 w_next = S_IDLE;
    endcase
  end

  always_comb begin
    sqrt_enb_o  = 1'b0;
    rsp_valid_o = 1'b0;
    busy_o      = 1'b1;
    unique case (r_state)
      S_IDLE:  busy_o      = 1'b0;
      S_RUN:   sqrt_enb_o  = 1'b1;
      S_RESP:  rsp_valid_o = 1'b1;
      default: busy_o      = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
      r_id  <= '0;
      r_op  <= '0;
      r_rsp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_grant) begin
        r_op  <= req_data_i[{w_win, 3'b000} +: 8];
        r_id  <= w_win;
        r_ptr <= (w_win == IDW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
      end
      if (r_state == S_RUN) begin
        r_cnt <= w_last ? '0 : r_cnt + 8'd1;
        if (w_last)
          r_rsp <= sqrt_dt_i;
      end
    end
  end

  assign sqrt_dt_o  = r_op;
  assign rsp_id_o   = r_id;
  assign rsp_data_o = r_rsp;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter with a behavioural
// multi-cycle square-root datapath attached.
module tb_sqrt_arbiter;

  localparam int N   = 4;
  localparam int LAT = 15;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [N-1:0] req_valid_i;
  logic [8*N-1:0] req_data_i;
  logic [N-1:0] req_ready_o;
  logic         rsp_valid_o;
  logic [1:0]   rsp_id_o;
  logic [7:0]   rsp_data_o;
  logic         rsp_ready_i;
  logic [7:0]   sqrt_dt_o;
  logic         sqrt_enb_o;
  logic [7:0]   sqrt_dt_i = 8'hEE;
  logic         busy_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sqrt_arbiter #(.N_REQ(N), .SQRT_LAT(LAT)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_id_o    (rsp_id_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_ready_i (rsp_ready_i),
    .sqrt_dt_o   (sqrt_dt_o),
    .sqrt_enb_o  (sqrt_enb_o),
    .sqrt_dt_i   (sqrt_dt_i),
    .busy_o      (busy_o)
  );

  function automatic logic [7:0] isqrt(input int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return 8'(r);
  endfunction

  // Result becomes valid once enable has been high LAT cycles
  // with an unchanged operand; 8'hEE marks "not ready yet".
  logic [7:0] m_op  = 8'h00;
  int         m_cnt = 0;
  always @(negedge clk) begin
    if (sqrt_enb_o) begin
      if (m_cnt > 0 && sqrt_dt_o == m_op) begin
        m_cnt = m_cnt + 1;
      end else begin
        m_cnt = 1;
        m_op  = sqrt_dt_o;
      end
    end else begin
      m_cnt = 0;
    end
    sqrt_dt_i = (m_cnt >= LAT) ? isqrt(int'(m_op)) : 8'hEE;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle; returns in the IDLE cycle after the handshake
  task automatic run_one(input int k, input logic [7:0] op,
                         input logic [7:0] exp);
    req_data_i[8*k +: 8] = op;
    req_valid_i = 4'(1 << k);
    rsp_ready_i = 1'b1;
    #1;
    chk("grant", 32'(req_ready_o), 32'(1 << k));
    step();
    req_valid_i = '0;
    #1;
    chk("run_enb", 32'(sqrt_enb_o), 1);
    chk("run_dt", 32'(sqrt_dt_o), 32'(op));
    chk("run_rdy", 32'(req_ready_o), 0);
    repeat (LAT - 1) step();
    chk("pre_rsp", 32'(rsp_valid_o), 0);
    step();
    chk("rsp_valid", 32'(rsp_valid_o), 1);
    chk("rsp_id", 32'(rsp_id_o), 32'(k));
    chk("rsp_data", 32'(rsp_data_o), 32'(exp));
    step();
    chk("back_idle", 32'(busy_o), 0);
  endtask

  initial begin
    logic [7:0] f_exp [4];
    int         f_seq [5];
    f_exp = '{8'd3, 8'd7, 8'd10, 8'd14};
    f_seq = '{0, 1, 2, 3, 0};

    rst_i       = 1'b1;
    req_valid_i = '0;
    req_data_i  = '0;
    rsp_ready_i = 1'b0;
    step();
    step();
    req_valid_i = 4'hF;
    #1;
    chk("rst_rdy", 32'(req_ready_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_rspv", 32'(rsp_valid_o), 0);
    chk("rst_id", 32'(rsp_id_o), 0);
    chk("rst_data", 32'(rsp_data_o), 0);
    chk("rst_dt", 32'(sqrt_dt_o), 0);
    chk("rst_enb", 32'(sqrt_enb_o), 0);
    req_valid_i = '0;
    rst_i = 1'b0;
    step();
    #1;
    chk("idle_norq", 32'(req_ready_o), 0);
    step();
    chk("idle_stay", 32'(busy_o), 0);

    run_one(2, 8'd144, 8'd12);
    chk("idle_dt_hold", 32'(sqrt_dt_o), 144);
    chk("idle_enb", 32'(sqrt_enb_o), 0);
    run_one(0, 8'd0, 8'd0);
    run_one(0, 8'd1, 8'd1);
    run_one(0, 8'd255, 8'd15);
    for (int x = 0; x < 256; x++)
      run_one(0, 8'(x), isqrt(x));

    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    req_data_i  = {8'd200, 8'd100, 8'd50, 8'd9};
    req_valid_i = 4'hF;
    rsp_ready_i = 1'b1;
    for (int g = 0; g < 5; g++) begin
      #1;
      chk("fair_grant", 32'(req_ready_o), 32'(1 << f_seq[g]));
      step();
      chk("fair_run_rdy", 32'(req_ready_o), 0);
      repeat (LAT - 1) step();
      step();
      chk("fair_rspv", 32'(rsp_valid_o), 1);
      chk("fair_id", 32'(rsp_id_o), 32'(f_seq[g]));
      chk("fair_data", 32'(rsp_data_o), 32'(f_exp[f_seq[g]]));
      step();
    end

    req_data_i  = {8'd200, 8'd0, 8'd81, 8'd0};
    req_valid_i = 4'b1010;
    rsp_ready_i = 1'b0;
    #1;
    chk("bp_grant", 32'(req_ready_o), 32'b0010);
    step();
    req_valid_i = 4'b1000;
    repeat (LAT - 1) step();
    rsp_ready_i = 1'b1;
    #1;
    chk("bp_early_rdy", 32'(rsp_valid_o), 0);
    rsp_ready_i = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rspv", 32'(rsp_valid_o), 1);
      chk("bp_id", 32'(rsp_id_o), 1);
      chk("bp_data", 32'(rsp_data_o), 9);
      chk("bp_rdy", 32'(req_ready_o), 0);
      chk("bp_enb", 32'(sqrt_enb_o), 0);
      step();
    end
    rsp_ready_i = 1'b1;
    #1;
    chk("bp_last", 32'(rsp_valid_o), 1);
    step();
    chk("bp_next", 32'(req_ready_o), 32'b1000);
    step();
    req_valid_i = '0;
    repeat (LAT - 1) step();
    step();
    chk("bp2_id", 32'(rsp_id_o), 3);
    chk("bp2_data", 32'(rsp_data_o), 14);
    step();

    req_data_i  = {8'd200, 8'd0, 8'd100, 8'd0};
    req_valid_i = 4'b0010;
    #1;
    chk("mr_grant", 32'(req_ready_o), 32'b0010);
    step();
    req_valid_i = '0;
    repeat (7) step();
    rst_i = 1'b1;
    #1;
    chk("mr_rdy", 32'(req_ready_o), 0);
    step();
    chk("mr_busy", 32'(busy_o), 0);
    chk("mr_enb", 32'(sqrt_enb_o), 0);
    chk("mr_rspv", 32'(rsp_valid_o), 0);
    chk("mr_dt", 32'(sqrt_dt_o), 0);
    rst_i = 1'b0;
    req_valid_i = 4'b1010;
    #1;
    chk("mr_ptr0", 32'(req_ready_o), 32'b0010);
    step();
    req_valid_i = '0;
    repeat (LAT - 1) step();
    step();
    chk("mr2_id", 32'(rsp_id_o), 1);
    chk("mr2_data", 32'(rsp_data_o), 10);
    step();
    run_one(3, 8'd200, 8'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
